spimemio_arb: RTL

SPIMEMIO_ARB -- requirements
Module: spimemio_arb

---
 rtl/spimemio_arb.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spimemio_arb.sv
// spimemio_arb: arbiter in front of a single spimemio flash controller port.
// Two read requesters (m0, m1) share the controller. Config register writes
// take priority over reads, and each is followed by a 3-cycle settle window.
//
// Ports:
//   clk, resetn                    clock (rising edge) / synchronous active-low reset
//   mX_valid, mX_addr              requester X read request and byte address
//   mX_ready, mX_err, mX_rdata     requester X completion strobe, timeout flag, data
//   cfg_we, cfg_di, cfg_ack        config write request (nonzero we), data, accept strobe
//   mem_valid, mem_addr            read request to the flash controller
//   mem_ready, mem_rdata           read response from the flash controller
//   cfgreg_we, cfgreg_di           config write to the flash controller
//   busy                           arbiter not idle
module spimemio_arb #(
  parameter int TIMEOUT    = 1024,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [23:0] m0_addr,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [23:0] m1_addr,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  input  logic [3:0]  cfg_we,
  input  logic [31:0] cfg_di,
  output logic        cfg_ack,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  cfgreg_we,
  output logic [31:0] cfgreg_di,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RD, CFG, HOLD} state_t;

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'd2;

  state_t      state, state_nx;
  logic        gnt, gnt_nx;     // 0 = m0, 1 = m1
  logic        last;            // last requester served, 1 = m1
  logic [23:0] addr_q;
  logic [15:0] cnt;             // RD wait cycles, or HOLD cycles
  logic [3:0]  we_q;
  logic [31:0] di_q;

  logic g_valid, tmo, rd_live, rd_done, rd_abort;

  assign g_valid  = gnt ? m1_valid : m0_valid;
  // mem_ready wins over timeout in the same cycle
  assign tmo      = (cnt == TMO_LAST) && !mem_ready;
  assign rd_live  = (state == RD) && g_valid;
  assign rd_done  = rd_live && (mem_ready || tmo);
  assign rd_abort = (state == RD) && !g_valid;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      IDLE: begin
        if (|cfg_we) begin
          state_nx = CFG;
        end else if (m0_valid || m1_valid) begin
          state_nx = RD;
          if (m0_valid && m1_valid)
            gnt_nx = FIXED_PRIO ? 1'b0 : ~last;
          else
            gnt_nx = m1_valid;
        end
      end
      RD:      if (rd_done || rd_abort) state_nx = IDLE;
      CFG:     state_nx = HOLD;
      HOLD:    if (cnt == HOLD_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
      cnt    <= '0;
      we_q   <= '0;
      di_q   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      if (state == IDLE && state_nx == RD)
        addr_q <= gnt_nx ? m1_addr : m0_addr;
      if (state == IDLE && |cfg_we) begin
        we_q <= cfg_we;
        di_q <= cfg_di;
      end
      // every state change restarts the count, so RD and HOLD both begin at 0
      if (state_nx != state)
        cnt <= '0;
      else if ((state == RD && !mem_ready) || state == HOLD)
        cnt <= cnt + 16'd1;
      if (rd_done || rd_abort)
        last <= gnt;
    end
  end

  // Strobes are qualified with resetn so a reset landing mid-transaction
  // never leaks a completion or ack in that cycle.
  always_comb begin
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    if (resetn && rd_live) begin
      if (!gnt) begin
        m0_ready = mem_ready || tmo;
        m0_err   = tmo;
        m0_rdata = tmo ? 32'hFFFF_FFFF : mem_rdata;
      end else begin
        m1_ready = mem_ready || tmo;
        m1_err   = tmo;
        m1_rdata = tmo ? 32'hFFFF_FFFF : mem_rdata;
      end
    end
  end

  assign mem_valid = (state == RD);
  assign mem_addr  = addr_q;
  assign cfg_ack   = resetn && (state == CFG);
  assign cfgreg_we = cfg_ack ? we_q : 4'h0;
  assign cfgreg_di = di_q;
  assign busy      = (state != IDLE);

endmodule
